// File: rtl/mem_access_ctrl.sv
// Data-memory port sequencer for the memory stage: splits wide accesses
// into two 16-bit beats, handshakes each beat and stalls upstream meanwhile.
module mem_access_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_write,
    input  logic              i_wide,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic              i_mem_ready,
    input  logic [15:0]       i_mem_rdata,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              wide_q, wide_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              in_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wide_q  <= wide_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        wide_d  = wide_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (i_req) begin
                    wr_d    = i_write;
                    wide_d  = i_wide;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                if (i_mem_ready) begin
                    cnt_d = '0;
                    if (!wr_q) begin
                        if (state_q == BEAT1) begin
                            rdata_d[31:16] = i_mem_rdata;
                        end else begin
                            rdata_d[15:0] = i_mem_rdata;
                            if (!wide_q) rdata_d[31:16] = '0;
                        end
                    end
                    state_d = (state_q == BEAT0 && wide_q) ? BEAT1 : DONE;
                end else if (cnt_q == MAX_CNT) begin
                    // Abort: halves not yet captured keep their old value
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_beat     = (state_q == BEAT0) || (state_q == BEAT1);
    assign o_mem_re    = in_beat && !wr_q;
    assign o_mem_we    = in_beat && wr_q;
    assign o_mem_addr  = addr_q + ADDR_W'(state_q == BEAT1);
    assign o_mem_wdata = (state_q == BEAT1) ? wdata_q[31:16] : wdata_q[15:0];
    assign o_rdata     = rdata_q;
    // Low in DONE so upstream buffers advance exactly once per access
    assign o_stall     = ((state_q == IDLE) && i_req) || in_beat;
    assign o_done      = (state_q == DONE);
    assign o_err       = (state_q == DONE) && err_q;

endmodule
